// File: rtl/serial_pkg.sv
// Shared serial-link definitions: the frame FSM state encoding and line levels,
// used by both the transmit and receive sides.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Counter width for a modulo-n count; a 1-bit counter still exists when n is 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Word-side valid/ready handshake between a producer and the serial transmitter.
interface serial_tx_if #(
    parameter int unsigned W = 8
) ();
    logic         valid;
    logic [W-1:0] data;
    logic         ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: modulo-CLKS_PER_BIT counter whose tick marks the last clock of a bit.
module bit_timer
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset_L,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int unsigned    CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count and tick; the tick fires on the wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Framed parallel-in/serial-out transmitter: start bit, w data bits, optional even
// parity (enabled by defining SERIAL_TX_PARITY_EN), stop bit; CLKS_PER_BIT clocks per bit.
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned w            = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          MSB_FIRST    = 1'b0
) (
    input  logic          clock,
    input  logic          reset_L,
    serial_tx_if.slave    tx_if,
    output logic          serial_out,
    output logic          busy,
    output logic          done
);
    localparam int unsigned IW = cnt_width(w);

    tx_state_t     state_q, state_d;
    logic [w-1:0]  shift_q, shift_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          serial_out_q, serial_out_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          timer_clr_s;
    logic          timer_en_s;
    logic          tick_s;
`ifdef SERIAL_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock  (clock),
        .reset_L(reset_L),
        .clr    (timer_clr_s),
        .en     (timer_en_s),
        .tick   (tick_s)
    );

    // Frame sequencing: accept, advance one bit per timer tick.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        timer_clr_s = 1'b0;
        timer_en_s  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_if.valid && ready_q) begin
                    shift_d     = tx_if.data;
                    idx_d       = '0;
                    timer_clr_s = 1'b1;
                    state_d     = START;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d    = ^tx_if.data;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                timer_en_s = 1'b1;
                if (tick_s) begin
                    state_d = DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                timer_en_s = 1'b1;
                if (tick_s) begin
                    if (MSB_FIRST) begin
                        shift_d = shift_q << 1;
                    end else begin
                        shift_d = shift_q >> 1;
                    end
                    if (idx_q == IW'(w - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    state_d = DATA;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                timer_en_s = 1'b1;
                if (tick_s) begin
                    state_d = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
`endif
            STOP: begin
                timer_en_s = 1'b1;
                if (tick_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with it once registered.
    always_comb begin
        serial_out_d = IDLE_LEVEL;
        case (state_d)
            IDLE:  serial_out_d = IDLE_LEVEL;
            START: serial_out_d = START_BIT;
            DATA:  serial_out_d = MSB_FIRST ? shift_d[w-1] : shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY: serial_out_d = parity_d;
`endif
            STOP:  serial_out_d = STOP_BIT;
            default: serial_out_d = IDLE_LEVEL;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_q == STOP) && (state_d == IDLE);
    end

    // State and output registers; reset returns the line to idle at once.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            idx_q        <= '0;
            serial_out_q <= IDLE_LEVEL;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            serial_out_q <= serial_out_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign tx_if.ready = ready_q;
    assign serial_out  = serial_out_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: three instances (LSB/C=4, MSB/C=2, LSB/C=1)
// compared cycle by cycle against a frame model built from the framing rules.
module tb_serial_tx;

    logic       clock = 1'b0;
    logic       reset_L = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    int         sel = 0;
    int         total = 0;
    int         bad = 0;
    logic       exp_q[$];

`ifdef SERIAL_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    int cpb[3] = '{4, 2, 1};
    bit msb[3] = '{1'b0, 1'b1, 1'b0};

    always #5 clock = ~clock;

    serial_tx_if #(.W(8)) if0 ();
    serial_tx_if #(.W(8)) if1 ();
    serial_tx_if #(.W(8)) if2 ();

    assign if0.valid = valid && (sel == 0);
    assign if1.valid = valid && (sel == 1);
    assign if2.valid = valid && (sel == 2);
    assign if0.data  = data;
    assign if1.data  = data;
    assign if2.data  = data;

    logic so0, so1, so2, b0, b1, b2, d0, d1, d2;
    logic obs_out, obs_rdy, obs_busy, obs_done;

    serial_tx #(.w(8), .CLKS_PER_BIT(4), .MSB_FIRST(1'b0)) dut0 (
        .clock(clock), .reset_L(reset_L), .tx_if(if0.slave),
        .serial_out(so0), .busy(b0), .done(d0));
    serial_tx #(.w(8), .CLKS_PER_BIT(2), .MSB_FIRST(1'b1)) dut1 (
        .clock(clock), .reset_L(reset_L), .tx_if(if1.slave),
        .serial_out(so1), .busy(b1), .done(d1));
    serial_tx #(.w(8), .CLKS_PER_BIT(1), .MSB_FIRST(1'b0)) dut2 (
        .clock(clock), .reset_L(reset_L), .tx_if(if2.slave),
        .serial_out(so2), .busy(b2), .done(d2));

    always_comb begin
        case (sel)
            1:       begin obs_out = so1; obs_rdy = if1.ready; obs_busy = b1; obs_done = d1; end
            2:       begin obs_out = so2; obs_rdy = if2.ready; obs_busy = b2; obs_done = d2; end
            default: begin obs_out = so0; obs_rdy = if0.ready; obs_busy = b0; obs_done = d0; end
        endcase
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected line level for every cycle of one frame, from the framing rules.
    task automatic build_exp(input logic [7:0] word, input int s);
        int   bits[$];
        int   v;
        v = int'(word);
        exp_q.delete();
        bits.push_back(0);
        for (int i = 0; i < 8; i++) begin
            if (msb[s]) bits.push_back((v >> (7 - i)) % 2);
            else        bits.push_back((v >> i) % 2);
        end
        if (PBITS == 1) bits.push_back($countones(word) % 2);
        bits.push_back(1);
        foreach (bits[b]) begin
            for (int c = 0; c < cpb[s]; c++) exp_q.push_back(bits[b] != 0);
        end
    endtask

    // Called at a negedge: present a word; it is accepted at the following posedge.
    task automatic start_frame(input logic [7:0] word);
        chk("ready_before_accept", obs_rdy, 1'b1);
        valid = 1'b1;
        data  = word;
    endtask

    // mode 0: drop valid after accept, 1: hold valid/data, 2: random valid/data noise.
    task automatic check_frame(input logic [7:0] word, input int mode,
                               input logic next_valid, input logic [7:0] next_word);
        build_exp(word, sel);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clock);
            chk($sformatf("line[%0d] dut%0d word=%h", k, sel, word), obs_out, exp_q[k]);
            chk("ready_in_frame", obs_rdy, 1'b0);
            chk("busy_in_frame", obs_busy, 1'b1);
            chk("done_in_frame", obs_done, 1'b0);
            if (mode == 0) begin
                valid = 1'b0;
            end else if (mode == 2) begin
                valid = 1'($urandom_range(0, 1));
                data  = 8'($urandom);
            end
        end
        @(negedge clock);
        chk($sformatf("done_pulse dut%0d", sel), obs_done, 1'b1);
        chk("ready_at_done", obs_rdy, 1'b1);
        chk("busy_at_done", obs_busy, 1'b0);
        chk("line_at_done", obs_out, 1'b1);
        valid = next_valid;
        data  = next_word;
        if (!next_valid) begin
            @(negedge clock);
            chk("done_one_cycle", obs_done, 1'b0);
            chk("line_idle_after", obs_out, 1'b1);
        end
    endtask

    initial begin
        logic [7:0] w_r;
        repeat (2) @(negedge clock);
        chk("rst_line0", so0, 1'b1);
        chk("rst_ready0", if0.ready, 1'b1);
        chk("rst_busy0", b0, 1'b0);
        chk("rst_done0", d0, 1'b0);
        chk("rst_line1", so1, 1'b1);
        chk("rst_line2", so2, 1'b1);
        reset_L = 1'b1;
        @(negedge clock);

        // LSB first, 4 clocks per bit
        sel = 0;
        start_frame(8'hA5);
        check_frame(8'hA5, 0, 1'b0, 8'h00);

        // MSB first
        sel = 1;
        start_frame(8'hA5);
        check_frame(8'hA5, 0, 1'b0, 8'h00);

        // back-to-back with valid held high
        sel = 0;
        start_frame(8'h01);
        check_frame(8'h01, 1, 1'b1, 8'h80);
        check_frame(8'h80, 0, 1'b0, 8'h00);

        // valid pulse withdrawn before any edge: nothing sent
        valid = 1'b1;
        data  = 8'h55;
        #2 valid = 1'b0;
        repeat (4) begin
            @(negedge clock);
            chk("no_accept_line", obs_out, 1'b1);
            chk("no_accept_busy", obs_busy, 1'b0);
            chk("no_accept_ready", obs_rdy, 1'b1);
        end

        // reset during data bit 3 of 8'hFF
        start_frame(8'hFF);
        repeat (18) begin
            @(negedge clock);
            valid = 1'b0;
        end
        chk("pre_reset_busy", obs_busy, 1'b1);
        reset_L = 1'b0;
        #1;
        chk("abort_line", obs_out, 1'b1);
        chk("abort_ready", obs_rdy, 1'b1);
        chk("abort_busy", obs_busy, 1'b0);
        @(negedge clock);
        reset_L = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("abort_no_done", obs_done, 1'b0);
            chk("abort_line_idle", obs_out, 1'b1);
        end
        w_r = 8'($urandom);
        start_frame(w_r);
        check_frame(w_r, 0, 1'b0, 8'h00);

        // one bit per clock
        sel = 2;
        start_frame(8'h07);
        check_frame(8'h07, 0, 1'b0, 8'h00);

        // random words with valid/data noise while busy
        for (int i = 0; i < 6; i++) begin
            sel = i % 3;
            w_r = 8'($urandom);
            start_frame(w_r);
            check_frame(w_r, 2, 1'b0, 8'h00);
            valid = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
